demux14_double: RTL and testbench

//  Registered 1-to-4 demultiplexer for the NVBoard 2-bit datapath: routes a W-bit value X

---
 rtl/demux14_double_pkg.sv | 11 +
 rtl/demux14_double_btn_debounce.sv | 60 ++++++
 rtl/demux14_double.sv | 98 +++++++++
 tb/tb_demux14_double.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux14_double_pkg.sv
// Shared constants for the 2-bit demultiplexer / selector datapath.
//   NCH   : number of output channels
//   SEL_W : width of the channel-select input
//   CNT_W : width of the accepted-write counter
package demux14_double_pkg;

   localparam int NCH   = 4;
   localparam int SEL_W = 2;
   localparam int CNT_W = 8;

endpackage

// File: rtl/demux14_double_btn_debounce.sv
// Push-button front end: 2-flop synchronizer, debounce and rising-edge detect.
// Ports:
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   btn_raw     in  asynchronous raw button level, active-high
//   press_pulse out one-cycle pulse per accepted press; release produces nothing
module demux14_double_btn_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press_pulse
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          stable_q, stable_d;
   logic          stable_dly_q;
   logic          press_q, press_d;

   always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      // Any return to agreement restarts the count, so only an uninterrupted
      // run of DB_CYCLES differing cycles flips the stable level.
      if (sync2_q != stable_q) begin
         if (cnt_q == CW'(DB_CYCLES - 1)) begin
            stable_d = sync2_q;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
      press_d = stable_q & ~stable_dly_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         cnt_q        <= '0;
         stable_q     <= 1'b0;
         stable_dly_q <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= btn_raw;
         sync2_q      <= sync1_q;
         cnt_q        <= cnt_d;
         stable_q     <= stable_d;
         stable_dly_q <= stable_q;
         press_q      <= press_d;
      end
   end

   assign press_pulse = press_q;

endmodule

// File: rtl/demux14_double.sv
// Registered 1-to-4 demultiplexer: writes X into the held channel register
// selected by Y on a debounced button press or a direct write strobe.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   X [W]         data to distribute
//   Y [2]         destination channel
//   btn           raw push-button write request
//   wr_en         synchronous write strobe (bypasses debounce)
//   clr           synchronous clear of all channels (wr_cnt kept)
//   F0..F3 [W]    held channel registers
//   F_all [4*W]   {F3,F2,F1,F0}
//   vld [4]       channel written since reset/clr
//   upd [4]       one-cycle pulse when a channel takes new data
//   wr_cnt [8]    accepted-write count, wrapping
module demux14_double
   import demux14_double_pkg::*;
#(
   parameter int W         = 2,
   parameter int DB_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [W-1:0]       X,
   input  logic [SEL_W-1:0]   Y,
   input  logic               btn,
   input  logic               wr_en,
   input  logic               clr,
   output logic [W-1:0]       F0,
   output logic [W-1:0]       F1,
   output logic [W-1:0]       F2,
   output logic [W-1:0]       F3,
   output logic [NCH*W-1:0]   F_all,
   output logic [NCH-1:0]     vld,
   output logic [NCH-1:0]     upd,
   output logic [CNT_W-1:0]   wr_cnt
);

   logic             wr_btn;
   logic             wr;
   logic [W-1:0]     f_q [NCH];
   logic [W-1:0]     f_d [NCH];
   logic [NCH-1:0]   vld_q, vld_d;
   logic [NCH-1:0]   upd_q, upd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   demux14_double_btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_btn (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn),
      .press_pulse (wr_btn)
   );

   // A press and a strobe in the same cycle merge into a single write.
   assign wr = wr_btn | wr_en;

   always_comb begin
      for (int i = 0; i < NCH; i++) f_d[i] = f_q[i];
      vld_d = vld_q;
      upd_d = '0;
      cnt_d = cnt_q;
      // clr has priority: a coincident write is dropped and not counted.
      if (clr) begin
         for (int i = 0; i < NCH; i++) f_d[i] = '0;
         vld_d = '0;
      end else if (wr) begin
         f_d[Y]   = X;
         vld_d[Y] = 1'b1;
         upd_d[Y] = 1'b1;
         cnt_d    = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) f_q[i] <= '0;
         vld_q <= '0;
         upd_q <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) f_q[i] <= f_d[i];
         vld_q <= vld_d;
         upd_q <= upd_d;
         cnt_q <= cnt_d;
      end
   end

   assign F0     = f_q[0];
   assign F1     = f_q[1];
   assign F2     = f_q[2];
   assign F3     = f_q[3];
   assign F_all  = {f_q[3], f_q[2], f_q[1], f_q[0]};
   assign vld    = vld_q;
   assign upd    = upd_q;
   assign wr_cnt = cnt_q;

endmodule

// File: tb/tb_demux14_double.sv
module tb_demux14_double;

   localparam int W   = 2;
   localparam int DBC = 4;
   // A press is visible 2 sync + DBC + 1 edge + 1 write cycles after the rise.
   localparam int PRESS_LAT = 2 + DBC + 1 + 1;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic [1:0] X     = '0;
   logic [1:0] Y     = '0;
   logic       btn   = 1'b0;
   logic       wr_en = 1'b0;
   logic       clr   = 1'b0;
   logic [1:0] F0, F1, F2, F3;
   logic [7:0] F_all;
   logic [3:0] vld, upd;
   logic [7:0] wr_cnt;

   demux14_double #(.W(W), .DB_CYCLES(DBC)) dut (
      .clk    (clk),
      .rst    (rst),
      .X      (X),
      .Y      (Y),
      .btn    (btn),
      .wr_en  (wr_en),
      .clr    (clr),
      .F0     (F0),
      .F1     (F1),
      .F2     (F2),
      .F3     (F3),
      .F_all  (F_all),
      .vld    (vld),
      .upd    (upd),
      .wr_cnt (wr_cnt)
   );

   always #5 clk = ~clk;

   int vecs  = 0;
   int fails = 0;

   // Reference model: four storage cells, valid flags, update pulse, counter.
   logic [1:0] m_f [4];
   logic [3:0] m_vld;
   logic [3:0] m_upd;
   logic [7:0] m_cnt;

   function automatic logic [31:0] exp_vec();
      return {m_f[3], m_f[2], m_f[1], m_f[0],
              m_f[3], m_f[2], m_f[1], m_f[0], m_vld, m_upd, m_cnt};
   endfunction

   function automatic logic [31:0] act_vec();
      return {F3, F2, F1, F0, F_all, vld, upd, wr_cnt};
   endfunction

   // One clock edge; btn_wr says the debounced press is due on this edge.
   task automatic tick(input logic btn_wr);
      @(posedge clk);
      m_upd = 4'b0000;
      if (rst) begin
         for (int i = 0; i < 4; i++) m_f[i] = 2'b00;
         m_vld = 4'b0000;
         m_cnt = 8'd0;
      end else if (clr) begin
         for (int i = 0; i < 4; i++) m_f[i] = 2'b00;
         m_vld = 4'b0000;
      end else if (wr_en || btn_wr) begin
         m_f[Y]   = X;
         m_vld[Y] = 1'b1;
         m_upd    = 4'b0001 << Y;
         m_cnt    = m_cnt + 8'd1;
      end
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; wr_en = 1'b0; clr = 1'b0; btn = 1'b0;
      tick(1'b0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b1; X = 2'd3; Y = 2'd1; clr = 1'b0;
      tick(1'b0);
      tick(1'b0);
      if (act_vec() !== exp_vec()) begin
         fails++; $display("FAIL reset_model: got %h expected %h", act_vec(), exp_vec());
      end
      vecs++;
      if (act_vec() !== 32'h0) begin
         fails++; $display("FAIL reset_zero: got %h expected 00000000", act_vec());
      end
      vecs++;
      rst = 1'b0; wr_en = 1'b0;
   endtask

   task automatic test_single_write();
      X = 2'b10; Y = 2'd2; wr_en = 1'b1;
      tick(1'b0);
      wr_en = 1'b0;
      if (act_vec() !== exp_vec()) begin
         fails++; $display("FAIL single_write: got %h expected %h", act_vec(), exp_vec());
      end
      vecs++;
      if ({F2, vld, upd, wr_cnt} !== {2'd2, 4'b0100, 4'b0100, 8'd1}) begin
         fails++; $display("FAIL single_write_const: got %h expected %h",
                           {F2, vld, upd, wr_cnt}, {2'd2, 4'b0100, 4'b0100, 8'd1});
      end
      vecs++;
      tick(1'b0);
      if (act_vec() !== exp_vec() || upd !== 4'b0000) begin
         fails++; $display("FAIL upd_drop: got %h expected %h", act_vec(), exp_vec());
      end
      vecs++;
   endtask

   task automatic test_walk();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         Y = 2'(i); X = 2'(3 - i); wr_en = 1'b1;
         tick(1'b0);
         if (act_vec() !== exp_vec() || upd !== (4'b0001 << i)) begin
            fails++; $display("FAIL walk[%0d]: got %h expected %h", i, act_vec(), exp_vec());
         end
         vecs++;
      end
      wr_en = 1'b0;
      if ({F_all, vld, wr_cnt} !== {8'b00_01_10_11, 4'hF, 8'd4}) begin
         fails++; $display("FAIL walk_final: got %h expected %h",
                           {F_all, vld, wr_cnt}, {8'b00_01_10_11, 4'hF, 8'd4});
      end
      vecs++;
   endtask

   task automatic test_clr_wins();
      Y = 2'd3; X = 2'd3; wr_en = 1'b1; clr = 1'b1;
      tick(1'b0);
      wr_en = 1'b0; clr = 1'b0;
      if (act_vec() !== exp_vec()) begin
         fails++; $display("FAIL clr_wins: got %h expected %h", act_vec(), exp_vec());
      end
      vecs++;
      if ({F_all, vld, upd, wr_cnt} !== {8'h00, 4'h0, 4'h0, 8'd4}) begin
         fails++; $display("FAIL clr_wins_const: got %h expected %h",
                           {F_all, vld, upd, wr_cnt}, {8'h00, 4'h0, 4'h0, 8'd4});
      end
      vecs++;
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         X     = 2'($urandom_range(0, 3));
         Y     = 2'($urandom_range(0, 3));
         wr_en = ($urandom_range(0, 99) < 60);
         clr   = ($urandom_range(0, 99) < 5);
         tick(1'b0);
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL random[%0d]: got %h expected %h", n, act_vec(), exp_vec());
         end
         vecs++;
      end
      wr_en = 1'b0; clr = 1'b0;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int n = 0; n < 256; n++) begin
         X = 2'($urandom_range(0, 3)); Y = 2'($urandom_range(0, 3)); wr_en = 1'b1;
         tick(1'b0);
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL wrap[%0d]: got %h expected %h", n, act_vec(), exp_vec());
         end
         vecs++;
      end
      wr_en = 1'b0;
      if (wr_cnt !== 8'd0) begin
         fails++; $display("FAIL wrap_zero: got %0d expected 0", wr_cnt);
      end
      vecs++;
   endtask

   task automatic test_btn_glitch();
      logic [7:0] cnt0;
      cnt0 = m_cnt;
      X = 2'd3; Y = 2'd3; btn = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         tick(1'b0);
         if (k == 3) btn = 1'b0;
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL btn_glitch[%0d]: got %h expected %h", k, act_vec(), exp_vec());
         end
         vecs++;
      end
      if (wr_cnt !== cnt0) begin
         fails++; $display("FAIL btn_glitch_cnt: got %0d expected %0d", wr_cnt, cnt0);
      end
      vecs++;
   endtask

   task automatic test_btn_press();
      int pulses;
      pulses = 0;
      X = 2'd1; Y = 2'd1; btn = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick(k == PRESS_LAT);
         if (k == 10) btn = 1'b0;
         if (upd[1]) pulses++;
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL btn_press[%0d]: got %h expected %h", k, act_vec(), exp_vec());
         end
         vecs++;
      end
      if (pulses != 1 || F1 !== 2'd1) begin
         fails++; $display("FAIL btn_press_once: got pulses=%0d F1=%0d expected pulses=1 F1=1",
                           pulses, F1);
      end
      vecs++;
   endtask

   task automatic test_btn_rst_mid();
      X = 2'd2; Y = 2'd0; btn = 1'b1;
      for (int k = 1; k <= 4; k++) tick(1'b0);
      rst = 1'b1; btn = 1'b0;
      tick(1'b0);
      rst = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         tick(1'b0);
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL btn_rst_mid[%0d]: got %h expected %h", k, act_vec(), exp_vec());
         end
         vecs++;
      end
      if (wr_cnt !== 8'd0 || vld !== 4'h0) begin
         fails++; $display("FAIL btn_rst_mid_final: got cnt=%0d vld=%h expected cnt=0 vld=0",
                           wr_cnt, vld);
      end
      vecs++;
   endtask

   task automatic test_btn_and_wren();
      logic [7:0] cnt0;
      cnt0 = m_cnt;
      X = 2'd2; Y = 2'd0; btn = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         wr_en = (k == PRESS_LAT);
         tick(k == PRESS_LAT);
         wr_en = 1'b0;
         if (k == 10) btn = 1'b0;
         if (act_vec() !== exp_vec()) begin
            fails++; $display("FAIL btn_and_wren[%0d]: got %h expected %h", k, act_vec(), exp_vec());
         end
         vecs++;
      end
      if (wr_cnt !== cnt0 + 8'd1) begin
         fails++; $display("FAIL btn_and_wren_cnt: got %0d expected %0d", wr_cnt, cnt0 + 8'd1);
      end
      vecs++;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) m_f[i] = 2'b00;
      m_vld = '0; m_upd = '0; m_cnt = '0;
      test_reset();
      test_single_write();
      test_walk();
      test_clr_wins();
      test_random();
      test_wrap();
      test_btn_glitch();
      test_btn_press();
      test_btn_rst_mid();
      test_btn_and_wren();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
